// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder / instruction-memory program loader
//
// Packs an instruction class plus its fields into a 32-bit RV32I word and
// writes it to instruction memory at an auto-incrementing byte address.
// One word is accepted per valid/ready handshake and written on the
// following cycle, so throughput is one word every two cycles.
//
// Optional feature macro: ENC_RANGE_CHECK_EN
//   defined     : out-of-range / misaligned immediates are rejected (err_imm)
//   not defined : immediates are truncated by the packing, err_imm tied 0
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   clear                  synchronous restart: address, count and errors
//   in_valid / in_ready    field handshake
//   in_type                0 R,1 I,2 STORE,3 LOAD,4 BRANCH,5 JAL,6 JALR,7 AUIPC,8 LUI
//   in_rd/in_rs1/in_rs2    register fields
//   in_funct3/in_funct7    function fields
//   in_imm                 immediate (byte offset for BRANCH/JAL, full value for U-type)
//   imem_we/addr/wdata     instruction memory write port
//   word_count, full       words written since reset/clear, count reached DEPTH
//   err_type, err_imm      sticky error flags
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_type,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic [6:0]    in_funct7,
  input  logic [31:0]   in_imm,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [CW-1:0] word_count,
  output logic          full,
  output logic          err_type,
  output logic          err_imm
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state, next_state;
  logic [31:0] enc_word;
  logic        type_ok;
  logic        imm_ok;
  logic        accept;

  // Field packing; type_ok drops for the reserved classes 9-15.
  always_comb begin
    enc_word = '0;
    type_ok  = 1'b1;
    unique case (in_type)
      4'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      4'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
      4'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
      4'd3: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_L};
      4'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OP_B};
      4'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      4'd6: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      4'd7: enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
      4'd8: enc_word = {in_imm[31:12], in_rd, OP_LUI};
      default: type_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // A value fits a signed N-bit field when every bit above N-1 equals bit N-1.
  logic fits12, fits13, fits21;
  assign fits12 = (in_imm[31:11] == {21{in_imm[11]}});
  assign fits13 = (in_imm[31:12] == {20{in_imm[12]}});
  assign fits21 = (in_imm[31:20] == {12{in_imm[20]}});

  always_comb begin
    imm_ok = 1'b1;
    case (in_type)
      4'd1, 4'd2, 4'd3, 4'd6: imm_ok = fits12;
      4'd4:                   imm_ok = fits13 && !in_imm[0];
      4'd5:                   imm_ok = fits21 && !in_imm[0];
      4'd7, 4'd8:             imm_ok = (in_imm[11:0] == 12'h000);
      default:                imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign full = (word_count == CW'(DEPTH));

  // clear wins over a coincident handshake: the word is dropped, not latched.
  assign accept = in_valid && in_ready && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // in_ready is qualified by rst_n so it reads 0 while reset is held.
  // imem_we comes straight from the async-reset state, so reset aborts a
  // pending write immediately; clear aborts it in the same cycle.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n && !full;
        if (accept && type_ok && imm_ok) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        imem_we    = !clear;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (clear) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      word_count <= '0;
      err_type   <= 1'b0;
    end else if (clear) begin
      imem_addr  <= BASE_ADDR;
      word_count <= '0;
      err_type   <= 1'b0;
    end else if (state == WRITE) begin
      imem_addr  <= imem_addr + 32'd4;
      word_count <= word_count + 1'b1;
    end else if (accept) begin
      if (!type_ok) begin
        err_type <= 1'b1;
      end else if (imm_ok) begin
        imem_wdata <= enc_word;
      end
    end
  end

`ifdef ENC_RANGE_CHECK_EN
  // An illegal type takes precedence, so err_imm only flags legal classes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_imm <= 1'b0;
    end else if (clear) begin
      err_imm <= 1'b0;
    end else if (state == IDLE && accept && type_ok && !imm_ok) begin
      err_imm <= 1'b1;
    end
  end
`else
  assign err_imm = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder with randomized fields
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          CW    = $clog2(DEPTH) + 1;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, clear, in_valid, in_ready;
  logic [3:0]    in_type;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          imem_we;
  logic [31:0]   imem_addr, imem_wdata;
  logic [CW-1:0] word_count;
  logic          full, err_type, err_imm;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .full(full), .err_type(err_type), .err_imm(err_imm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr;
  int          exp_count;
  bit          exp_et, exp_ei;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: place each field at its bit offset with shifts and masks.
  function automatic logic [31:0] ref_enc(input int t, input logic [31:0] rd, rs1, rs2,
                                          f3, f7, imm);
    logic [31:0] ops [9];
    logic [31:0] w;
    ops = '{32'h33, 32'h13, 32'h23, 32'h03, 32'h63, 32'h6F, 32'h67, 32'h17, 32'h37};
    w = ops[t];
    case (t)
      0: w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
      1, 3: w |= (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      6: w |= (rd << 7) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      2: w |= ((imm & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
              | (((imm >> 5) & 32'h7F) << 25);
      4: w |= (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8) | (f3 << 12)
              | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 32'h3F) << 25)
              | (((imm >> 12) & 1) << 31);
      5: w |= (rd << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 1) << 20)
              | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 1) << 31);
      default: w |= (rd << 7) | (imm & 32'hFFFF_F000);
    endcase
    return w;
  endfunction

  function automatic bit range_ok(input int t, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (t)
      1, 2, 3, 6: return (s >= -2048) && (s <= 2047);
      4:          return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
      5:          return (s >= -(1 << 20)) && (s < (1 << 20)) && (imm[0] == 1'b0);
      7, 8:       return (imm & 32'hFFF) == 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] gen_imm(input int t);
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return r;
    case (t)
      1, 2, 3, 6: return {{20{r[11]}}, r[11:0]};
      4:          return {{19{r[12]}}, r[12:1], 1'b0};
      5:          return {{11{r[20]}}, r[20:1], 1'b0};
      7, 8:       return {r[31:12], 12'h000};
      default:    return r;
    endcase
  endfunction

  // Called on the accept edge: update the expected memory image.
  task automatic model_accept(input int t, input logic [31:0] rd, rs1, rs2, f3, f7, imm,
                              input bit use_exp, input logic [31:0] exp_w);
    if (t > 8) begin
      exp_et = 1'b1;
    end else if (RC && !range_ok(t, imm)) begin
      exp_ei = 1'b1;
    end else begin
      q.push_back('{a: exp_addr, d: (use_exp ? exp_w : ref_enc(t, rd, rs1, rs2, f3, f7, imm))});
      exp_addr += 32'd4;
      exp_count++;
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send(input int t, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input bit use_exp, input logic [31:0] exp_w);
    int n;
    in_type = t[3:0]; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %b for type %0d, required 1", in_ready, t);
    end else begin
      @(posedge clk);
      model_accept(t, 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7), imm, use_exp, exp_w);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    int t;
    t = $urandom_range(0, 10);
    send(t, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
         gen_imm(t), 1'b0, 32'h0);
  endtask

  task automatic drain();
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    exp_addr = BASE; exp_count = 0; exp_et = 1'b0; exp_ei = 1'b0;
  endtask

  task automatic do_clear();
    in_valid = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
  endtask

  task automatic check_status(input string nm);
    chk({nm, "_count"}, 32'(word_count), 32'(exp_count));
    chk({nm, "_full"}, 32'(full), 32'(exp_count == DEPTH));
    chk({nm, "_err_type"}, 32'(err_type), 32'(exp_et));
    chk({nm, "_err_imm"}, 32'(err_imm), 32'(exp_ei));
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && imem_we) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %h data %h, required no write", imem_addr, imem_wdata);
        end else begin
          e = q.pop_front();
          chk("write_addr", imem_addr, e.a);
          chk("write_data", imem_wdata, e.d);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_type = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 32'h0);
    check_status("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    send(0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b1, 32'h002081B3);
    chk("we_next_cycle", 32'(imem_we), 32'd1);
    drain();
    check_status("r_type");

    do_clear();
    send(1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00293);
    send(2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020A423);
    drain();

    do_clear();
    send(4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE000EE3);
    send(5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h008000EF);
    send(8, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h123452B7);
    drain();
    check_status("b_jal_lui");

    do_clear();
    send(15, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0);
    chk("illegal_ready_next", 32'(in_ready), 32'd1);
    drain();
    check_status("illegal");

    do_clear();
    send(1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h80000293);
    drain();
    check_status("imm2048");

    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      send(0, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
           32'h0, 1'b0, 32'h0);
    end
    in_valid = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    drain();
    check_status("full");
    do_clear();
    chk("clear_addr", imem_addr, BASE);
    check_status("after_clear");

    in_type = 4'd0; in_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    drain();
    check_status("clear_drop");

    send(0, 5'd7, 5'd8, 5'd9, 3'd1, 7'd3, 32'h0, 1'b0, 32'h0);
    clear = 1'b1;
    void'(q.pop_back());
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    drain();
    chk("abort_addr", imem_addr, BASE);
    check_status("clear_abort");

    send(0, 5'd7, 5'd8, 5'd9, 3'd1, 7'd3, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("reset_abort_we", 32'(imem_we), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_status("reset_abort");

    repeat (40) begin
      int n;
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) send_rand();
      drain();
      check_status("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
